// File: rtl/push_btn_db_if.sv
// push_btn_db_if: MMIO slot bus between the bus fabric and an I/O core.
// Master drives strobes, address and write data; slave returns read data.
interface push_btn_db_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, read, write, addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/push_btn_db.sv
// push_btn_db: debounced push-button MMIO slot core.
// Sync + counter debounce, sticky W1C edge flags, maskable level irq.
module push_btn_db #(
  parameter int N_BTN     = 3,
  parameter int DB_CYCLES = 2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  push_btn_db_if.slave     bus,
  input  logic [N_BTN-1:0] din,
  output logic             irq
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [N_BTN-1:0] db;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] rise_en;
  logic [N_BTN-1:0] fall_en;
  logic [CW-1:0]    cnt [N_BTN];

  logic [N_BTN-1:0] hit;
  logic [N_BTN-1:0] db_nx;
  logic [N_BTN-1:0] rise_set;
  logic [N_BTN-1:0] fall_set;
  logic [N_BTN-1:0] rise_clr;
  logic [N_BTN-1:0] fall_clr;
  logic [N_BTN-1:0] wbits;
  logic             we;
  logic             we_rise;
  logic             we_fall;
  logic             we_en;
  logic [31:0]      rd_mux;

  // hit: channel disagreed with db for DB_CYCLES straight cycles
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_BTN; i++) begin
      hit[i] = (s2[i] != db[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign db_nx    = (db & ~hit) | (s2 & hit);
  assign rise_set = hit & s2;
  assign fall_set = hit & ~s2;

  assign we      = bus.cs & bus.write;
  assign we_rise = we && (bus.addr == 5'd1);
  assign we_fall = we && (bus.addr == 5'd2);
  assign we_en   = we && (bus.addr == 5'd3);
  assign wbits   = bus.wr_data[N_BTN-1:0];

  assign rise_clr = we_rise ? wbits : '0;
  assign fall_clr = we_fall ? wbits : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= din;
      s2 <= s1;
      db <= db_nx;
      for (int i = 0; i < N_BTN; i++) begin
        if (s2[i] == db[i] || hit[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // a new edge in the same cycle as a clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise    <= '0;
      fall    <= '0;
      rise_en <= '0;
      fall_en <= '0;
      irq     <= 1'b0;
    end else begin
      rise <= (rise & ~rise_clr) | rise_set;
      fall <= (fall & ~fall_clr) | fall_set;
      if (we_en) begin
        rise_en <= bus.wr_data[N_BTN-1:0];
        fall_en <= bus.wr_data[16+N_BTN-1:16];
      end
      irq <= (|(rise & rise_en)) | (|(fall & fall_en));
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      (bus.addr == 5'd0): rd_mux[N_BTN-1:0] = db;
      (bus.addr == 5'd1): rd_mux[N_BTN-1:0] = rise;
      (bus.addr == 5'd2): rd_mux[N_BTN-1:0] = fall;
      (bus.addr == 5'd3): begin
        rd_mux[N_BTN-1:0]     = rise_en;
        rd_mux[16+N_BTN-1:16] = fall_en;
      end
      default: rd_mux = '0;
    endcase
  end

  assign bus.rd_data = bus.cs ? rd_mux : 'z;

  logic unused_bus;
  assign unused_bus = ^{bus.read, bus.wr_data};
endmodule

// File: tb/tb_push_btn_db.sv
// tb_push_btn_db: directed table + hand sequences for push_btn_db.
// DB_CYCLES=4, N_BTN=3: debounce, W1C flags, irq, async reset.
module tb_push_btn_db;
  logic       clk;
  logic       rst;
  logic [2:0] din;
  logic       irq;

  int checks;
  int errors;

  push_btn_db_if bus ();

  push_btn_db #(
    .N_BTN     (3),
    .DB_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .din (din),
    .irq (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  din;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    int          n;
    logic [4:0]  raddr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } step_t;

  step_t tbl[$];

  function automatic step_t mk(
    input logic [2:0]  d,
    input logic        we,
    input logic [4:0]  wa,
    input logic [31:0] wd,
    input int          n,
    input logic [4:0]  ra,
    input logic [31:0] exp_rd,
    input logic        exp_irq
  );
    step_t s;
    s.din     = d;
    s.we      = we;
    s.waddr   = wa;
    s.wdata   = wd;
    s.n       = n;
    s.raddr   = ra;
    s.exp_rd  = exp_rd;
    s.exp_irq = exp_irq;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_row(input step_t r, input int idx);
    din         = r.din;
    bus.write   = r.we;
    bus.addr    = r.we ? r.waddr : r.raddr;
    bus.wr_data = r.wdata;
    tick();
    bus.write = 1'b0;
    repeat (r.n - 1) tick();
    bus.addr = r.raddr;
    #1;
    check($sformatf("row%0d rd", idx), bus.rd_data, r.exp_rd);
    check($sformatf("row%0d irq", idx), {31'b0, irq}, {31'b0, r.exp_irq});
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.addr    = a;
    bus.wr_data = d;
    bus.write   = 1'b1;
    tick();
    bus.write = 1'b0;
  endtask

  logic hz_ok;

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    din         = '0;
    bus.cs      = 1'b1;
    bus.read    = 1'b1;
    bus.write   = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;

    // glitch shorter than the debounce window
    tbl.push_back(mk(3'd1, 0, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 8, 0, 0, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 1, 1, 0, 0));
    // press: db rises on the 6th edge
    tbl.push_back(mk(3'd1, 0, 0, 0, 5, 0, 0, 0));
    tbl.push_back(mk(3'd1, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(3'd1, 0, 0, 0, 1, 1, 1, 0));
    // release: fall on the 6th edge
    tbl.push_back(mk(3'd0, 0, 0, 0, 5, 2, 0, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 1, 2, 1, 0));
    // W1C
    tbl.push_back(mk(3'd0, 1, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(3'd0, 1, 2, 0, 1, 2, 1, 0));
    tbl.push_back(mk(3'd0, 1, 2, 1, 1, 2, 0, 0));
    // clear coincident with new rise
    tbl.push_back(mk(3'd1, 0, 0, 0, 5, 0, 0, 0));
    tbl.push_back(mk(3'd1, 1, 1, 1, 1, 1, 1, 0));
    tbl.push_back(mk(3'd1, 0, 0, 0, 1, 0, 1, 0));
    // irq
    tbl.push_back(mk(3'd1, 1, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(3'd1, 1, 3, 32'h0001_0001, 1, 3, 32'h0001_0001, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 5, 2, 0, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 1, 2, 1, 0));
    tbl.push_back(mk(3'd0, 0, 0, 0, 1, 2, 1, 1));
    tbl.push_back(mk(3'd0, 1, 2, 1, 1, 2, 0, 1));
    tbl.push_back(mk(3'd0, 0, 0, 0, 1, 2, 0, 0));
    tbl.push_back(mk(3'd1, 0, 0, 0, 6, 1, 1, 0));
    tbl.push_back(mk(3'd1, 0, 0, 0, 1, 1, 1, 1));
    tbl.push_back(mk(3'd1, 1, 1, 1, 1, 1, 0, 1));
    tbl.push_back(mk(3'd1, 0, 0, 0, 1, 1, 0, 0));
    // unmapped address and unused bits
    tbl.push_back(mk(3'd1, 1, 5, 32'hffff_ffff, 1, 5, 0, 0));
    tbl.push_back(mk(3'd1, 0, 0, 0, 1, 3, 32'h0001_0001, 0));
    tbl.push_back(mk(3'd1, 1, 3, 32'hffff_ffff, 1, 3, 32'h0007_0007, 0));
    tbl.push_back(mk(3'd1, 1, 3, 0, 1, 3, 0, 0));
    // multi-channel press
    tbl.push_back(mk(3'd7, 0, 0, 0, 6, 0, 7, 0));
    tbl.push_back(mk(3'd7, 0, 0, 0, 1, 1, 6, 0));

    // reset state
    tick();
    tick();
    for (int a = 0; a < 4; a++) begin
      bus.addr = 5'(a);
      #1;
      check($sformatf("reset addr%0d", a), bus.rd_data, 32'h0);
    end
    check("reset irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) run_row(tbl[i], i);

    // deselected slot does not drive the bus (db=7 here)
    bus.addr = 5'd0;
    bus.cs   = 1'b0;
    #1;
    hz_ok = (bus.rd_data === 32'hzzzz_zzzz) || (bus.rd_data == 32'h0);
    check("cs0 rd_data", {31'b0, hz_ok}, 32'h1);
    bus.cs = 1'b1;
    #1;
    check("cs1 db", bus.rd_data, 32'h7);
    tick();

    // async reset while cnt[0]=3
    wr(5'd3, 32'h0001_0001);
    din = 3'd0;
    repeat (10) tick();
    din = 3'd1;
    repeat (5) tick();
    bus.addr = 5'd2;
    #1;
    check("pre-rst fall", bus.rd_data, 32'h7);
    rst = 1'b1;
    #1;
    for (int a = 0; a < 4; a++) begin
      bus.addr = 5'(a);
      #1;
      check($sformatf("async rst addr%0d", a), bus.rd_data, 32'h0);
    end
    check("async rst irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    tick();
    bus.addr = 5'd1;
    repeat (4) tick();
    check("post-rst rise 5", bus.rd_data, 32'h0);
    tick();
    check("post-rst rise 6", bus.rd_data, 32'h1);
    bus.addr = 5'd0;
    #1;
    check("post-rst db", bus.rd_data, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
